// File: rtl/sprite_motion_ctrl_pkg.sv
// Shared constants for sprite_motion_ctrl: PS/2 set-2 scan codes, decoder states, key_held bit indices.
package sprite_motion_ctrl_pkg;

    localparam logic [7:0] KEY_W      = 8'h1D;
    localparam logic [7:0] KEY_S      = 8'h1B;
    localparam logic [7:0] KEY_A      = 8'h1C;
    localparam logic [7:0] KEY_D      = 8'h23;
    localparam logic [7:0] KEY_UP     = 8'h75;
    localparam logic [7:0] KEY_DOWN   = 8'h72;
    localparam logic [7:0] KEY_LEFT   = 8'h6B;
    localparam logic [7:0] KEY_RIGHT  = 8'h74;
    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;

    localparam int unsigned BIT_UP    = 0;
    localparam int unsigned BIT_DOWN  = 1;
    localparam int unsigned BIT_LEFT  = 2;
    localparam int unsigned BIT_RIGHT = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BREAK,
        ST_EXT,
        ST_EXT_BREAK
    } kbd_state_t;

    // One-hot key_held mask for a WASD code, zero for anything else.
    function automatic logic [3:0] wasd_mask(input logic [7:0] code);
        logic [3:0] m;
        m = '0;
        case (code)
            KEY_W:   m[BIT_UP]    = 1'b1;
            KEY_S:   m[BIT_DOWN]  = 1'b1;
            KEY_A:   m[BIT_LEFT]  = 1'b1;
            KEY_D:   m[BIT_RIGHT] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] arrow_mask(input logic [7:0] code);
        logic [3:0] m;
        m = '0;
        case (code)
            KEY_UP:    m[BIT_UP]    = 1'b1;
            KEY_DOWN:  m[BIT_DOWN]  = 1'b1;
            KEY_LEFT:  m[BIT_LEFT]  = 1'b1;
            KEY_RIGHT: m[BIT_RIGHT] = 1'b1;
            default:   m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sprite_motion_ctrl_ps2_key_decoder.sv
// Set-2 make/break/extended prefix decoder producing the held-key vector.
// Arrow keys are decoded only when SPRITE_ARROW_KEYS_EN is defined.
module ps2_key_decoder
    import sprite_motion_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    output logic [3:0] key_held
);

    kbd_state_t state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            key_held <= '0;
        end else if (scan_valid) begin
            case (state)
                ST_IDLE: begin
                    if (scan_code == PS2_BREAK)
                        state <= ST_BREAK;
                    else if (scan_code == PS2_EXT)
                        state <= ST_EXT;
                    else
                        key_held <= key_held | wasd_mask(scan_code);
                end
                ST_BREAK: begin
                    key_held <= key_held & ~wasd_mask(scan_code);
                    state    <= ST_IDLE;
                end
                ST_EXT: begin
                    if (scan_code == PS2_BREAK) begin
                        state <= ST_EXT_BREAK;
                    end else begin
`ifdef SPRITE_ARROW_KEYS_EN
                        key_held <= key_held | arrow_mask(scan_code);
`endif
                        state <= ST_IDLE;
                    end
                end
                ST_EXT_BREAK: begin
`ifdef SPRITE_ARROW_KEYS_EN
                    key_held <= key_held & ~arrow_mask(scan_code);
`endif
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Sprite position stepper: moves the sprite once per frame_tick from held keys, clamped to the visible area.
// Optional arrow-key decoding via SPRITE_ARROW_KEYS_EN (see ps2_key_decoder).
module sprite_motion_ctrl
    import sprite_motion_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH    = 640,
    parameter int unsigned HEIGHT   = 480,
    parameter int unsigned SPRITE_W = 50,
    parameter int unsigned SPRITE_H = 50,
    parameter int unsigned STEP     = 4,
    parameter int unsigned INIT_X   = 0,
    parameter int unsigned INIT_Y   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    input  logic       frame_tick,
    output logic [9:0] sprite_x,
    output logic [8:0] sprite_y,
    output logic [3:0] key_held,
    output logic       pos_update
);

    localparam logic [10:0] X_MAX = 11'(WIDTH - SPRITE_W);
    localparam logic [10:0] Y_MAX = 11'(HEIGHT - SPRITE_H);
    localparam logic [10:0] STEP11 = 11'(STEP);

    ps2_key_decoder u_decoder (
        .clk        (clk),
        .reset      (reset),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .key_held   (key_held)
    );

    logic [10:0] x_cur, y_cur, x_sum, y_sum;
    logic [9:0]  next_x;
    logic [8:0]  next_y;
    logic        go_right, go_left, go_down, go_up;

    always_comb begin
        x_cur    = {1'b0, sprite_x};
        y_cur    = {2'b0, sprite_y};
        x_sum    = x_cur + STEP11;
        y_sum    = y_cur + STEP11;
        go_right = key_held[BIT_RIGHT] & ~key_held[BIT_LEFT];
        go_left  = key_held[BIT_LEFT]  & ~key_held[BIT_RIGHT];
        go_down  = key_held[BIT_DOWN]  & ~key_held[BIT_UP];
        go_up    = key_held[BIT_UP]    & ~key_held[BIT_DOWN];

        next_x = sprite_x;
        if (go_right)
            next_x = (x_sum > X_MAX) ? X_MAX[9:0] : x_sum[9:0];
        else if (go_left)
            next_x = (x_cur < STEP11) ? '0 : sprite_x - STEP11[9:0];

        next_y = sprite_y;
        if (go_down)
            next_y = (y_sum > Y_MAX) ? Y_MAX[8:0] : y_sum[8:0];
        else if (go_up)
            next_y = (y_cur < STEP11) ? '0 : sprite_y - STEP11[8:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sprite_x   <= 10'(INIT_X);
            sprite_y   <= 9'(INIT_Y);
            pos_update <= 1'b0;
        end else begin
            pos_update <= 1'b0;
            if (frame_tick) begin
                sprite_x   <= next_x;
                sprite_y   <= next_y;
                pos_update <= (next_x != sprite_x) || (next_y != sprite_y);
            end
        end
    end

endmodule
